// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - GNR attractor sweep controller: load, cycle search, period measure, result stream.
// Optional macro GNR_STATE_OUT_EN adds out_state (attractor representative captured at the period match).
module gnr_attractor_ctrl #(
    parameter int               N_NODES   = 8,
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] MAX_STEPS = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_first,
    input  logic [N_NODES-1:0] init_last,
    input  logic [N_NODES-1:0] nodes_s0,
    input  logic [N_NODES-1:0] nodes_s1,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_NODES-1:0] out_init,
    output logic [CNT_W-1:0]   out_period,
    output logic [CNT_W-1:0]   out_steps,
    output logic               out_timeout,
`ifdef GNR_STATE_OUT_EN
    output logic [N_NODES-1:0] out_state,
`endif
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_PERIOD,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state;
    logic [N_NODES-1:0] cur;
    logic [N_NODES-1:0] last;
    logic [CNT_W-1:0]   step_cnt;
    logic [CNT_W-1:0]   per_cnt;

    logic match;
    logic search_hit;
    logic search_exit;
    logic period_hit;
    logic period_exit;

    // Before two hare steps the tortoise and hare trivially agree, so the compare is masked.
    assign match       = (nodes_s0 == nodes_s1);
    assign search_hit  = (state == S_SEARCH) && match && (step_cnt >= CNT_W'(2));
    assign search_exit = search_hit || ((state == S_SEARCH) && (step_cnt == MAX_STEPS));
    assign period_hit  = (state == S_PERIOD) && match && (per_cnt != '0);
    assign period_exit = period_hit || ((state == S_PERIOD) && (per_cnt == MAX_STEPS));

    assign reset_nos  = (state == S_LOAD);
    assign init_state = reset_nos ? cur : '0;
    assign start_s0   = (state == S_SEARCH) && !search_exit;
    assign start_s1   = start_s0 || ((state == S_PERIOD) && !period_exit);
    assign out_valid  = (state == S_OUT);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur         <= '0;
            last        <= '0;
            step_cnt    <= '0;
            per_cnt     <= '0;
            out_init    <= '0;
            out_period  <= '0;
            out_steps   <= '0;
            out_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur   <= init_first;
                        last  <= init_last;
                        state <= (init_first > init_last) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    step_cnt    <= '0;
                    per_cnt     <= '0;
                    out_init    <= cur;
                    out_period  <= '0;
                    out_steps   <= '0;
                    out_timeout <= 1'b0;
                    state       <= S_SEARCH;
                end
                S_SEARCH: begin
                    if (search_hit) begin
                        out_steps <= step_cnt;
                        per_cnt   <= '0;
                        state     <= S_PERIOD;
                    end else if (step_cnt == MAX_STEPS) begin
                        out_steps   <= step_cnt;
                        out_timeout <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                S_PERIOD: begin
                    if (period_hit) begin
                        out_period <= per_cnt;
                        state      <= S_OUT;
                    end else if (per_cnt == MAX_STEPS) begin
                        out_period  <= per_cnt;
                        out_timeout <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    // Compare against last before incrementing so an all-ones range end never wraps.
                    if (out_ready) begin
                        if (cur == last) begin
                            state <= S_DONE;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GNR_STATE_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= '0;
        end else if (period_hit) begin
            out_state <= nodes_s1;
        end
    end
`endif

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - scoreboard bench for gnr_attractor_ctrl with a behavioural node array.
module tb_gnr_attractor_ctrl;

    localparam int MAXS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  init_first = '0;
    logic [7:0]  init_last = '0;
    logic [7:0]  nodes_s0 = '0;
    logic [7:0]  nodes_s1 = '0;
    logic        reset_nos, start_s0, start_s1;
    logic [7:0]  init_state;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_init;
    logic [15:0] out_period, out_steps;
    logic        out_timeout, busy, done;
`ifdef GNR_STATE_OUT_EN
    logic [7:0]  out_state;
`endif

    gnr_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(16'(MAXS))) dut (
        .clk(clk), .rst(rst), .start(start),
        .init_first(init_first), .init_last(init_last),
        .nodes_s0(nodes_s0), .nodes_s1(nodes_s1),
        .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_init(out_init), .out_period(out_period), .out_steps(out_steps),
        .out_timeout(out_timeout),
`ifdef GNR_STATE_OUT_EN
        .out_state(out_state),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Node update map: 0 identity, 1 mod-m ring on bits [2:0] with a one-step tail, 2 increment.
    int mode = 0;
    int m = 1;

    function automatic logic [7:0] fnext(input logic [7:0] x);
        int lo;
        case (mode)
            0: return x;
            1: begin
                lo = int'(x[2:0]);
                lo = (lo >= m) ? 0 : (lo + 1) % m;
                return {x[7:3], 3'(lo)};
            end
            default: return x + 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] fpow(input logic [7:0] x, input int k);
        logic [7:0] y = x;
        for (int i = 0; i < k; i++) y = fnext(y);
        return y;
    endfunction

    typedef struct {
        logic [7:0] init;
        int         steps;
        int         period;
        bit         timeout;
        int         s0n;
        int         s1n;
    } exp_t;

    exp_t sbq[$];

    // After k hare steps the tortoise has made ceil(k/2) steps.
    task automatic model(input logic [7:0] x, output exp_t e);
        logic [7:0] y;
        e.init = x; e.timeout = 1'b0; e.steps = -1; e.period = 0;
        for (int k = 2; k <= MAXS; k++) begin
            if (fpow(x, k) == fpow(x, (k + 1) / 2)) begin
                e.steps = k;
                break;
            end
        end
        if (e.steps < 0) begin
            e.steps = MAXS; e.timeout = 1'b1; e.s0n = MAXS; e.s1n = MAXS;
        end else begin
            y = fpow(x, e.steps);
            e.period = -1;
            for (int p = 1; p <= MAXS; p++) begin
                if (fpow(y, p) == y) begin
                    e.period = p;
                    break;
                end
            end
            if (e.period < 0) begin
                e.period = MAXS; e.timeout = 1'b1;
            end
            e.s0n = e.steps;
            e.s1n = e.steps + e.period;
        end
    endtask

    logic tort_par = 1'b0;
    always @(posedge clk) begin
        if (reset_nos) begin
            nodes_s0 <= init_state;
            nodes_s1 <= init_state;
            tort_par <= 1'b0;
        end else begin
            if (start_s1) nodes_s1 <= fnext(nodes_s1);
            if (start_s0) begin
                if (!tort_par) nodes_s0 <= fnext(nodes_s0);
                tort_par <= !tort_par;
            end
        end
    end

    bit stall_mode = 1'b0;
    int stall_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!out_valid) begin
                stall_cnt = 0;
                out_ready = 1'($urandom % 2);
            end else if (stall_mode) begin
                out_ready = (stall_cnt >= 5);
                stall_cnt++;
            end else begin
                out_ready = 1'($urandom % 2);
            end
        end
    end

    int n_load = 0, n_s0 = 0, n_s1 = 0, n_done = 0, n_results = 0;
    logic [7:0] load_init = '0;
    bit stalled = 1'b0;
    logic [7:0]  h_init;
    logic [15:0] h_steps, h_period;
    logic        h_timeout;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            n_load = 0; n_s0 = 0; n_s1 = 0; stalled = 1'b0;
        end else begin
            if (reset_nos) begin
                n_load++;
                load_init = init_state;
            end
            if (start_s0) n_s0++;
            if (start_s1) n_s1++;
            if (done) n_done++;
            if (out_valid) begin
                check("strobes_in_out", {29'd0, reset_nos, start_s0, start_s1}, 32'd0);
                if (stalled) begin
                    check("stall_init", out_init, h_init);
                    check("stall_steps", out_steps, h_steps);
                    check("stall_period", out_period, h_period);
                    check("stall_timeout", out_timeout, h_timeout);
                end
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got init %0h, expected no result", out_init);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("out_init", out_init, mon_e.init);
                        check("out_timeout", out_timeout, mon_e.timeout);
                        if (!mon_e.timeout) begin
                            check("out_steps", out_steps, mon_e.steps);
                            check("out_period", out_period, mon_e.period);
                        end
                        check("load_cycles", n_load, 1);
                        check("load_init_state", load_init, mon_e.init);
                        check("s0_strobes", n_s0, mon_e.s0n);
                        check("s1_strobes", n_s1, mon_e.s1n);
                    end
                    n_load = 0; n_s0 = 0; n_s1 = 0;
                    n_results++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_init = out_init; h_steps = out_steps;
                    h_period = out_period; h_timeout = out_timeout;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic run(input logic [7:0] first, input logic [7:0] last, input bit glitch, output int lat);
        exp_t e;
        int n_exp = 0;
        int base_r, base_d;
        bit got = 1'b0;
        if (first <= last) begin
            for (int x = int'(first); x <= int'(last); x++) begin
                model(8'(x), e);
                sbq.push_back(e);
                n_exp++;
            end
        end
        base_r = n_results;
        base_d = n_done;
        @(negedge clk);
        init_first = first; init_last = last; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int cyc = 1; cyc < 5000; cyc++) begin
            #1;
            if (out_valid && lat < 0) lat = cyc;
            if (n_done > base_d) begin
                got = 1'b1;
                break;
            end
            if (glitch && cyc == 3) begin
                start = 1'b1; init_first = 8'hAA; init_last = 8'hAB;
            end
            if (glitch && cyc == 4) start = 1'b0;
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_wait: got no done pulse, expected one within 5000 cycles");
        end
        repeat (2) @(negedge clk);
        #1;
        check("done_pulses", n_done - base_d, 1);
        check("result_count", n_results - base_r, n_exp);
        check("scoreboard_empty", sbq.size(), 0);
        check("idle_after_done", busy, 1'b0);
        sbq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    int lat;
    logic [7:0] f0, l0;
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {reset_nos, start_s0, start_s1, out_valid, out_timeout, busy, done}, 0);
        check("rst_vectors", {init_state, out_init, out_steps}, 0);
        check("rst_period", out_period, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed point with first-result latency
        mode = 0;
        run(8'h05, 8'h05, 1'b0, lat);
        check("first_result_latency", lat, 7);

        // Period-3 ring
        mode = 1; m = 3;
        run(8'h00, 8'h00, 1'b0, lat);

        // Stalled sweep, with a start pulse while busy
        stall_mode = 1'b1;
        run(8'h00, 8'h03, 1'b1, lat);
        stall_mode = 1'b0;

        // Timeout, match exactly at the step limit, and one beyond it
        mode = 2;
        run(8'h10, 8'h10, 1'b0, lat);
        mode = 1; m = 5;
        run(8'h00, 8'h00, 1'b0, lat);
        m = 6;
        run(8'h00, 8'h00, 1'b0, lat);

        // Empty range and all-ones range end
        mode = 1; m = 2;
        run(8'h09, 8'h02, 1'b0, lat);
        check("empty_no_valid", lat, -1);
        run(8'hFE, 8'hFF, 1'b0, lat);

        // Reset during PERIOD
        mode = 1; m = 4;
        @(negedge clk);
        init_first = 8'h00; init_last = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (start_s1 && !start_s0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_period", seen, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs", {reset_nos, start_s0, start_s1, out_valid, out_timeout, busy, done}, 0);
        check("abort_vectors", {init_state, out_init, out_steps}, 0);
        check("abort_period", out_period, 0);
        @(negedge clk);
        rst = 1'b0;
        run(8'h00, 8'h01, 1'b0, lat);

        // Randomized maps and ranges
        for (int r = 0; r < 8; r++) begin
            mode = $urandom % 3;
            m = 1 + $urandom % 6;
            f0 = 8'($urandom);
            l0 = (f0 > 8'd252) ? 8'hFF : f0 + 8'($urandom % 4);
            run(f0, l0, 1'b0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
